pipeline_hazard_sequencer: RTL

- Central pipeline-control block for the 5-stage MIPS datapath (IF/ID/EX/MEM/WB, branch/jump/jr resolved in MEM).
- Generates per-stage write enables, bubble insertion and flushes.
- Detects load-use hazards and applies control-transfer flushes.
- Provides a debug single-step sequencer and saturating performance counters for stalls and flushes.

---
 rtl/pipeline_hazard_sequencer.sv | 93 +++++++++
 1 files changed

// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer: stage enables, load-use bubbles, redirect flushes, single-step FSM and perf counters
module pipeline_hazard_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_redirect,
  input  logic             step_mode,
  input  logic             step_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             pipe_write,
  output logic             idex_bubble,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic [1:0]       seq_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2
  } state_t;
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_adv;
  logic             w_load_use;
  logic             w_stall;
  logic             w_flush;
  assign w_adv      = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  // a redirect makes the stalled ID instruction wrong-path, so it wins over load-use
  assign w_flush    = Reset && w_adv && mem_redirect;
  assign w_stall    = Reset && w_adv && !mem_redirect && w_load_use;
  assign seq_state  = r_state;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;
  // sequencer state register; reset always returns to RUN and forgets any pending step
  always_ff @(posedge Clk) begin
    if (!Reset) r_state <= S_RUN;
    else        r_state <= w_next;
  end
  // next state: a step lasts one cycle regardless of what that cycle does in the pipe
  always_comb begin
    w_next = S_RUN;
    if (r_state == S_RUN)       w_next = step_mode ? S_HALT : S_RUN;
    else if (r_state == S_HALT) w_next = !step_mode ? S_RUN : (step_req ? S_STEP : S_HALT);
    else if (r_state == S_STEP) w_next = step_mode ? S_HALT : S_RUN;
  end
  // stage controls, zero-latency from inputs and current state
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    pipe_write  = 1'b0;
    idex_bubble = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    if (!Reset) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (w_adv) begin
      pc_write    = !w_stall;
      ifid_write  = !w_stall;
      pipe_write  = 1'b1;
      idex_bubble = w_stall;
      flush_ifid  = w_flush;
      flush_idex  = w_flush;
      flush_exmem = w_flush;
    end
  end
  // saturating performance counters, frozen while halted
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
endmodule
